// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: two-master, one-slave arbiter for the GPIO valid/ready peripheral bus.
// Latency: 1 cycle of arbitration (IDLE) before s_valid; completion passes straight through.
// Backpressure: the grant is held until s_ready, an owner abort or a timeout; then 1 forced IDLE cycle.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   m0_*/m1_*         : master request (valid/addr/wdata/wstrb in, ready/rdata/err out)
//   s_*               : slave request (valid/addr/wdata/wstrb out, ready/rdata in)
module gpio_bus_arbiter #(
  parameter logic [15:0] TIMEOUT   = 16'd256,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_owner, w_owner_nxt;
  logic        r_last,  w_last_nxt;
  logic [15:0] r_cnt,   w_cnt_nxt;

  logic        w_own_vld;
  logic        w_timeout;
  logic        w_done;
  logic        w_err;
  logic [31:0] w_rdata;

  assign w_own_vld = r_owner ? m1_valid : m0_valid;
  // TIMEOUT - 1 wraps to 16'hFFFF when TIMEOUT is 0, so the enable term is what disables it.
  assign w_timeout = (TIMEOUT != 16'd0) && (r_cnt == (TIMEOUT - 16'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;   // m0 wins the first tie
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_rdata     = 32'd0;
    s_valid     = 1'b0;
    s_addr      = 32'd0;
    s_wdata     = 32'd0;
    s_wstrb     = 4'd0;
    case (r_state)
      ST_IDLE: begin
        // Every exit from BUSY lands here for one cycle, which gives the slave its valid-low gap.
        if (m0_valid || m1_valid) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = 16'd0;
          w_owner_nxt = (m0_valid && m1_valid) ? ~r_last : m1_valid;
        end
      end
      ST_BUSY: begin
        s_valid = w_own_vld;
        s_addr  = r_owner ? m1_addr  : m0_addr;
        s_wdata = r_owner ? m1_wdata : m0_wdata;
        s_wstrb = r_owner ? m1_wstrb : m0_wstrb;
        w_done  = s_ready;
        w_rdata = s_rdata;
        // Priority: slave completion, then owner abort, then timeout.
        if (s_ready) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
        end else if (!w_own_vld) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
        end else if (w_timeout) begin
          w_done      = 1'b1;
          w_err       = 1'b1;
          w_rdata     = ERR_RDATA;
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
        end else if (r_cnt != 16'hFFFF) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
    endcase
  end

  // Completion signals are steered only by the registered owner, never by mX_valid directly.
  assign m0_ready = w_done & ~r_owner;
  assign m0_err   = w_err  & ~r_owner;
  assign m0_rdata = r_owner ? 32'd0 : w_rdata;
  assign m1_ready = w_done &  r_owner;
  assign m1_err   = w_err  &  r_owner;
  assign m1_rdata = r_owner ? w_rdata : 32'd0;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter (TIMEOUT=4): master/slave models plus
// per-master completion scoreboards and a global grant-order scoreboard.
module tb_gpio_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_valid, m0_ready, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_ready, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  gpio_bus_arbiter #(.TIMEOUT(16'd4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  hold;   // 0: hold valid until ready; N: drop valid after N cycles
  } req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } grant_t;

  req_t   rq0[$], rq1[$];
  exp_t   eq0[$], eq1[$];
  grant_t gq[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Model state (written only by the model process below)
  int          cyc = 0;
  logic        busy[2];
  logic        got_rdy[2];
  logic        mv[2];
  int          held[2];
  req_t        cur[2];
  int          t_vld_rise[2];
  int          n_rdy[2];
  int          t_svld_rise = 0;
  int          busy_n = 0;
  int          last_busy_n = 0;
  int          m1_nz = 0;
  int          sb = 0;
  logic        prev_sv = 1'b0;
  logic        prev_done = 1'b0;
  // Slave configuration (written only by the main sequence)
  int          slv_lat;
  logic        slv_ovr;
  logic [31:0] slv_val;

  task automatic monitor();
    logic done;
    exp_t e;
    grant_t g;
    done = 1'b0;
    if (prev_done) chk("gap_s_valid", 32'(s_valid), 32'd0);
    if (s_valid && !prev_sv) begin
      busy_n      = 1;
      t_svld_rise = cyc;
      if (gq.size() == 0) chk("grant_pending", 32'(gq.size()), 32'd1);
      else begin
        g = gq.pop_front();
        chk("grant_addr", s_addr, g.addr);
        chk("grant_wdata", s_wdata, g.wdata);
        chk("grant_wstrb", 32'(s_wstrb), 32'(g.wstrb));
      end
    end else if (s_valid) begin
      busy_n++;
    end
    if (m0_ready) begin
      n_rdy[0]++; done = 1'b1; got_rdy[0] = 1'b1; last_busy_n = busy_n;
      chk("one_ready", 32'(m1_ready), 32'd0);
      if (eq0.size() == 0) chk("m0_done_pending", 32'(eq0.size()), 32'd1);
      else begin
        e = eq0.pop_front();
        chk("m0_rdata", m0_rdata, e.rdata);
        chk("m0_err", 32'(m0_err), 32'(e.err));
      end
    end
    if (m1_ready) begin
      n_rdy[1]++; done = 1'b1; got_rdy[1] = 1'b1; last_busy_n = busy_n;
      if (eq1.size() == 0) chk("m1_done_pending", 32'(eq1.size()), 32'd1);
      else begin
        e = eq1.pop_front();
        chk("m1_rdata", m1_rdata, e.rdata);
        chk("m1_err", 32'(m1_err), 32'(e.err));
      end
    end
    if (m1_ready || m1_err || (m1_rdata != 32'd0)) m1_nz++;
    prev_sv   = s_valid;
    prev_done = done;
  endtask

  task automatic drive();
    cyc++;
    if (reset) begin
      rq0.delete(); rq1.delete(); eq0.delete(); eq1.delete(); gq.delete();
      for (int i = 0; i < 2; i++) begin
        busy[i] = 1'b0; got_rdy[i] = 1'b0; mv[i] = 1'b0; cur[i] = '0; held[i] = 0;
      end
      prev_sv = 1'b0; prev_done = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i] && got_rdy[i]) busy[i] = 1'b0;
        if (busy[i] && cur[i].hold != 8'd0 && held[i] == int'(cur[i].hold)) busy[i] = 1'b0;
        got_rdy[i] = 1'b0;
        if (!busy[i] && ((i == 0) ? rq0.size() : rq1.size()) > 0) begin
          if (i == 0) cur[i] = rq0.pop_front();
          else        cur[i] = rq1.pop_front();
          busy[i] = 1'b1;
          held[i] = 0;
          if (!mv[i]) t_vld_rise[i] = cyc;
        end
        if (busy[i]) begin
          mv[i] = 1'b1; held[i]++;
        end else begin
          mv[i] = 1'b0; cur[i] = '0;
        end
      end
    end
    m0_valid = mv[0]; m0_addr = cur[0].addr; m0_wdata = cur[0].wdata; m0_wstrb = cur[0].wstrb;
    m1_valid = mv[1]; m1_addr = cur[1].addr; m1_wdata = cur[1].wdata; m1_wstrb = cur[1].wstrb;
  endtask

  task automatic slave();
    if (reset) begin
      sb = 0; s_ready = 1'b0;
    end else if (s_valid) begin
      sb++;
      s_ready = (slv_lat >= 0) && (sb == slv_lat + 1);
    end else begin
      sb = 0; s_ready = 1'b0;
    end
    s_rdata = slv_ovr ? slv_val : slv_data(s_addr);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0; got_rdy[i] = 1'b0; mv[i] = 1'b0; held[i] = 0;
      cur[i] = '0; t_vld_rise[i] = 0; n_rdy[i] = 0;
    end
    m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    s_ready = 1'b0; s_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) monitor();
      @(posedge clk);
      #1 drive();
      #1 slave();
    end
  end

  task automatic push_req(input int i, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int hold, input logic exp_done,
                          input logic [31:0] exp_rd, input logic exp_err);
    req_t r; exp_t e; grant_t g;
    r.addr = addr; r.wdata = wdata; r.wstrb = wstrb; r.hold = 8'(hold);
    g.addr = addr; g.wdata = wdata; g.wstrb = wstrb;
    e.rdata = exp_rd; e.err = exp_err;
    gq.push_back(g);
    if (i == 0) begin
      rq0.push_back(r);
      if (exp_done) eq0.push_back(e);
    end else begin
      rq1.push_back(r);
      if (exp_done) eq1.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #2;
      if (rq0.size() == 0 && rq1.size() == 0 && eq0.size() == 0 && eq1.size() == 0 &&
          !busy[0] && !busy[1] && !s_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_drain"}, 32'(ok), 32'd1);
    chk({tag, "_grants_left"}, 32'(gq.size()), 32'd0);
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
  endtask

  int n0, n1, nz;

  initial begin
    reset = 1'b1; slv_lat = 1; slv_ovr = 1'b0; slv_val = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    reset = 1'b0;
    #2;

    // 1: single m0 write, slave answers one cycle after s_valid
    n0 = n_rdy[0]; n1 = n_rdy[1]; nz = m1_nz;
    push_req(0, 32'h1000, 32'h5A, 4'hF, 0, 1'b1, slv_data(32'h1000), 1'b0);
    wait_idle("t1");
    chk("t1_grant_latency", 32'(t_svld_rise - t_vld_rise[0]), 32'd1);
    chk("t1_m0_ready_pulses", 32'(n_rdy[0] - n0), 32'd1);
    chk("t1_m1_ready_pulses", 32'(n_rdy[1] - n1), 32'd0);
    chk("t1_m1_outputs_quiet", 32'(m1_nz - nz), 32'd0);

    // 2: both masters continuously valid, three transactions each -> strict alternation
    do_reset();
    n0 = n_rdy[0]; n1 = n_rdy[1];
    for (int k = 0; k < 3; k++) begin
      push_req(0, 32'h2000 + 32'(k), 32'h100 + 32'(k), 4'h1, 0, 1'b1, slv_data(32'h2000 + 32'(k)), 1'b0);
      push_req(1, 32'h3000 + 32'(k), 32'h200 + 32'(k), 4'h2, 0, 1'b1, slv_data(32'h3000 + 32'(k)), 1'b0);
    end
    wait_idle("t2");
    chk("t2_m0_count", 32'(n_rdy[0] - n0), 32'd3);
    chk("t2_m1_count", 32'(n_rdy[1] - n1), 32'd3);

    // 3: silent slave -> timeout error in the 4th BUSY cycle, then a normal m0 access
    slv_lat = -1;
    push_req(1, 32'h6000, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    wait_idle("t3");
    chk("t3_timeout_cycle", 32'(last_busy_n), 32'd4);
    slv_lat = 1;
    push_req(0, 32'h6100, 32'h33, 4'hC, 0, 1'b1, slv_data(32'h6100), 1'b0);
    wait_idle("t3b");

    // 4: s_ready coincides with the timeout cycle -> normal completion
    slv_lat = 3; slv_ovr = 1'b1; slv_val = 32'h12;
    push_req(1, 32'h7000, 32'h0, 4'h0, 0, 1'b1, 32'h12, 1'b0);
    wait_idle("t4");
    chk("t4_done_cycle", 32'(last_busy_n), 32'd4);
    slv_ovr = 1'b0; slv_lat = 1;

    // 5: m0 aborts after one BUSY cycle, pending m1 is served next
    do_reset();
    n0 = n_rdy[0]; n1 = n_rdy[1];
    push_req(0, 32'h8000, 32'h44, 4'hF, 2, 1'b0, 32'd0, 1'b0);
    push_req(1, 32'h8100, 32'h55, 4'hF, 0, 1'b1, slv_data(32'h8100), 1'b0);
    wait_idle("t5");
    chk("t5_m0_no_ready", 32'(n_rdy[0] - n0), 32'd0);
    chk("t5_m1_served", 32'(n_rdy[1] - n1), 32'd1);

    // 6: reset during BUSY clears the bus at once; m0 wins the first tie afterwards
    slv_lat = -1;
    push_req(0, 32'h9000, 32'h77, 4'h3, 0, 1'b0, 32'd0, 1'b0);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        #2;
        if (s_valid) begin
          seen = 1'b1;
          break;
        end
      end
      chk("t6_busy_reached", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_s_valid", 32'(s_valid), 32'd0);
    chk("t6_rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("t6_rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("t6_rst_s_addr", s_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    slv_lat = 1;
    #2;
    push_req(0, 32'hA000, 32'h11, 4'hF, 0, 1'b1, slv_data(32'hA000), 1'b0);
    push_req(1, 32'hA100, 32'h22, 4'hF, 0, 1'b1, slv_data(32'hA100), 1'b0);
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
